// File: rtl/noc_endpoint_pkg.sv
// Common helpers for the NoC endpoint (serializer and deserializer).
package noc_endpoint_pkg;

  // Counter wide enough to hold 0..w without wrapping.
  function automatic int bit_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/noc_endpoint_if.sv
// Host handshake and serial link bundle of one NoC endpoint.
`ifndef SIZE
`include "noc_2d_constants.sv"
`endif
interface noc_endpoint_if #(
  parameter int W = `SIZE
);
  logic [W-1:0] inj_data;
  logic         inj_valid;
  logic         inj_ready;
  logic         link_tx_data;
  logic         link_tx_busy;
  logic         link_rx_data;
  logic         link_rx_busy;
  logic [W-1:0] ej_data;
  logic         ej_valid;
  logic         ej_ready;

  modport slave (
    input  inj_data, inj_valid, link_tx_busy, link_rx_data, ej_ready,
    output inj_ready, link_tx_data, link_rx_busy, ej_data, ej_valid
  );

  modport master (
    output inj_data, inj_valid, link_tx_busy, link_rx_data, ej_ready,
    input  inj_ready, link_tx_data, link_rx_busy, ej_data, ej_valid
  );
endinterface

// File: rtl/noc_2d_constants.sv
// Shared constants for the 2D mesh NoC; SIZE is the default packet width in bits.
`ifndef NOC_2D_CONSTANTS_SV
`define NOC_2D_CONSTANTS_SV
`define SIZE 8
`endif

// File: rtl/noc_endpoint_ser.sv
// Injection serializer: start bit then W data bits LSB first on a registered line.
// Optional NOC_ENDPOINT_STATS_EN adds a saturating completed-frame counter.
module noc_endpoint_ser
  import noc_endpoint_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_tx,
  input  logic         i_busy
`ifdef NOC_ENDPOINT_STATS_EN
  ,
  output logic [15:0]  o_tx_count
`endif
);
  localparam int CW = bit_cnt_width(W);
  localparam logic [1:0] T_IDLE_ENC  = 2'd0;
  localparam logic [1:0] T_WAIT_ENC  = 2'd1;
  localparam logic [1:0] T_SHIFT_ENC = 2'd2;

  typedef enum logic [1:0] {
    T_IDLE  = T_IDLE_ENC,
    T_WAIT  = T_WAIT_ENC,
    T_SHIFT = T_SHIFT_ENC
  } tx_state_t;

  tx_state_t     r_state;
  logic [W:0]    r_sh;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_tx;

  // The start bit rides in r_sh[0], so count 0 drives it and count W drives the MSB.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= T_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_tx    <= 1'b0;
    end else begin
      case (r_state)
        T_IDLE: begin
          r_tx <= 1'b0;
          if (r_ready && i_valid) begin
            r_sh    <= {i_data, 1'b1};
            r_ready <= 1'b0;
            r_state <= T_WAIT;
          end else begin
            r_ready <= 1'b1;
          end
        end
        T_WAIT: begin
          if (!i_busy) begin
            r_cnt   <= '0;
            r_state <= T_SHIFT;
          end
        end
        T_SHIFT: begin
          r_tx <= r_sh[0];
          r_sh <= {1'b0, r_sh[W:1]};
          if (r_cnt == CW'(W)) begin
            r_cnt   <= '0;
            r_state <= T_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= T_IDLE;
          r_ready <= 1'b0;
          r_tx    <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_tx    = r_tx;

`ifdef NOC_ENDPOINT_STATS_EN
  logic [15:0] r_tx_count;

  // Saturating count of frames whose last data bit has been driven.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_count <= 16'h0000;
    end else if (r_state == T_SHIFT && r_cnt == CW'(W) && r_tx_count != 16'hFFFF) begin
      r_tx_count <= r_tx_count + 16'h0001;
    end
  end

  assign o_tx_count = r_tx_count;
`endif
endmodule

// File: rtl/noc_endpoint.sv
// NoC endpoint: serial link to the router local port, host inject/eject handshakes.
// Optional NOC_ENDPOINT_STATS_EN adds tx_count/rx_count outputs.
`ifndef SIZE
`include "noc_2d_constants.sv"
`endif
module noc_endpoint
  import noc_endpoint_pkg::*;
#(
  parameter int nodeid = -1,
  parameter int W      = `SIZE
) (
  input  logic           clk,
  input  logic           reset,
  noc_endpoint_if.slave  bus
`ifdef NOC_ENDPOINT_STATS_EN
  ,
  output logic [15:0]    tx_count,
  output logic [15:0]    rx_count
`endif
);
  localparam int CW = bit_cnt_width(W);
  localparam logic [1:0] R_IDLE_ENC  = 2'd0;
  localparam logic [1:0] R_SHIFT_ENC = 2'd1;
  localparam logic [1:0] R_HOLD_ENC  = 2'd2;

  typedef enum logic [1:0] {
    R_IDLE  = R_IDLE_ENC,
    R_SHIFT = R_SHIFT_ENC,
    R_HOLD  = R_HOLD_ENC
  } rx_state_t;

  rx_state_t     r_rx_state;
  logic [W-1:0]  r_rx_sh;
  logic [CW-1:0] r_rx_cnt;
  logic [W-1:0]  r_ej_data;
  logic          r_ej_valid;
  logic          r_rx_busy;

  noc_endpoint_ser #(
    .W (W)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .i_data     (bus.inj_data),
    .i_valid    (bus.inj_valid),
    .o_ready    (bus.inj_ready),
    .o_tx       (bus.link_tx_data),
    .i_busy     (bus.link_tx_busy)
`ifdef NOC_ENDPOINT_STATS_EN
    ,
    .o_tx_count (tx_count)
`endif
  );

  // Deserializer: ej_data is loaded once on the last bit so it stays stable through R_HOLD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_state <= R_IDLE;
      r_rx_sh    <= '0;
      r_rx_cnt   <= '0;
      r_ej_data  <= '0;
      r_ej_valid <= 1'b0;
      r_rx_busy  <= 1'b0;
    end else begin
      case (r_rx_state)
        R_IDLE: begin
          if (bus.link_rx_data) begin
            r_rx_cnt   <= '0;
            r_rx_busy  <= 1'b1;
            r_rx_state <= R_SHIFT;
          end
        end
        R_SHIFT: begin
          r_rx_sh <= {bus.link_rx_data, r_rx_sh[W-1:1]};
          if (r_rx_cnt == CW'(W - 1)) begin
            r_ej_data  <= {bus.link_rx_data, r_rx_sh[W-1:1]};
            r_ej_valid <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_state <= R_HOLD;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_HOLD: begin
          if (bus.ej_ready) begin
            r_ej_valid <= 1'b0;
            r_rx_busy  <= 1'b0;
            r_rx_state <= R_IDLE;
          end
        end
        default: begin
          r_rx_state <= R_IDLE;
          r_ej_valid <= 1'b0;
          r_rx_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A sender that ignores link_rx_busy loses its frame; make that visible in simulation.
  always_ff @(posedge clk) begin
    if (reset && r_rx_state == R_HOLD && bus.link_rx_data) begin
      $display("ERROR: noc_endpoint %0d: start bit during R_HOLD ignored", nodeid);
    end
  end
`endif

  assign bus.ej_data      = r_ej_data;
  assign bus.ej_valid     = r_ej_valid;
  assign bus.link_rx_busy = r_rx_busy;

`ifdef NOC_ENDPOINT_STATS_EN
  logic [15:0] r_rx_count;

  // Saturating count of completed ejection handshakes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_count <= 16'h0000;
    end else if (r_rx_state == R_HOLD && bus.ej_ready && r_rx_count != 16'hFFFF) begin
      r_rx_count <= r_rx_count + 16'h0001;
    end
  end

  assign rx_count = r_rx_count;
`endif
endmodule

// File: tb/tb_noc_endpoint.sv
// Directed self-checking bench for noc_endpoint with W=8.
`ifndef SIZE
`include "noc_2d_constants.sv"
`endif
module tb_noc_endpoint;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  noc_endpoint_if #(.W(8)) bus ();

`ifdef NOC_ENDPOINT_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] rx_count;
`endif

  noc_endpoint #(.nodeid(0), .W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef NOC_ENDPOINT_STATS_EN
    ,
    .tx_count (tx_count),
    .rx_count (rx_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_inj_ready();
    int n;
    n = 0;
    while (bus.inj_ready !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    n_checks++;
    if (bus.inj_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_inj_ready: inj_ready=%b after %0d cycles, required 1", bus.inj_ready, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.inj_ready !== 1'b0 || bus.link_tx_data !== 1'b0 || bus.link_rx_busy !== 1'b0 ||
        bus.ej_valid !== 1'b0 || bus.ej_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b tx=%b rxbusy=%b ejv=%b ejd=%h, required 0 0 0 0 00",
               bus.inj_ready, bus.link_tx_data, bus.link_rx_busy, bus.ej_valid, bus.ej_data);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (bus.inj_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: inj_ready=%b, required 1", bus.inj_ready);
    end
  endtask

  // Inject A5; busy rises mid-frame and must not disturb it.
  task automatic test_inject();
    logic [8:0] exp_bits;
    exp_bits = 9'b101001011;
    wait_inj_ready();
    bus.inj_data  = 8'hA5;
    bus.inj_valid = 1'b1;
    step();
    bus.inj_valid = 1'b0;
    step();
    n_checks++;
    if (bus.link_tx_data !== 1'b0 || bus.inj_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inject_cycle1: tx=%b ready=%b, required 0 0", bus.link_tx_data, bus.inj_ready);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      n_checks++;
      if (bus.link_tx_data !== exp_bits[i] || bus.inj_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL inject_bit%0d: tx=%b ready=%b, required %b 0", i, bus.link_tx_data,
                 bus.inj_ready, exp_bits[i]);
      end
      if (i == 4) bus.link_tx_busy = 1'b1;
    end
    step();
    n_checks++;
    if (bus.inj_ready !== 1'b1 || bus.link_tx_data !== 1'b0) begin
      n_fail++;
      $display("FAIL inject_ready_cycle11: ready=%b tx=%b, required 1 0", bus.inj_ready, bus.link_tx_data);
    end
    bus.link_tx_busy = 1'b0;
  endtask

  task automatic test_tx_busy();
    logic [8:0] exp_bits;
    exp_bits = 9'b001111001;
    wait_inj_ready();
    bus.link_tx_busy = 1'b1;
    bus.inj_data     = 8'h3C;
    bus.inj_valid    = 1'b1;
    step();
    bus.inj_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_checks++;
      if (bus.link_tx_data !== 1'b0 || bus.inj_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_hold_c%0d: tx=%b ready=%b, required 0 0", c, bus.link_tx_data, bus.inj_ready);
      end
    end
    bus.link_tx_busy = 1'b0;
    step();
    n_checks++;
    if (bus.link_tx_data !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_release: tx=%b, required 0", bus.link_tx_data);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      n_checks++;
      if (bus.link_tx_data !== exp_bits[i] || bus.inj_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_bit%0d: tx=%b ready=%b, required %b 0", i, bus.link_tx_data,
                 bus.inj_ready, exp_bits[i]);
      end
    end
    step();
    n_checks++;
    if (bus.inj_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ready_return: ready=%b, required 1", bus.inj_ready);
    end
  endtask

  task automatic test_eject();
    logic [7:0] d;
    d = 8'h81;
    bus.ej_ready     = 1'b0;
    bus.link_rx_data = 1'b1;
    step();
    n_checks++;
    if (bus.link_rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL eject_busy_after_start: busy=%b, required 1", bus.link_rx_busy);
    end
    for (int i = 0; i < 8; i++) begin
      bus.link_rx_data = d[i];
      step();
      if (i == 6) begin
        n_checks++;
        if (bus.ej_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL eject_early_valid: ej_valid=%b, required 0", bus.ej_valid);
        end
      end
    end
    bus.link_rx_data = 1'b0;
    n_checks++;
    if (bus.ej_valid !== 1'b1 || bus.ej_data !== 8'h81 || bus.link_rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL eject_frame: ejv=%b ejd=%h busy=%b, required 1 81 1", bus.ej_valid,
               bus.ej_data, bus.link_rx_busy);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus.ej_valid !== 1'b1 || bus.ej_data !== 8'h81 || bus.link_rx_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL eject_hold_c%0d: ejv=%b ejd=%h busy=%b, required 1 81 1", c,
                 bus.ej_valid, bus.ej_data, bus.link_rx_busy);
      end
    end
    bus.ej_ready = 1'b1;
    step();
    bus.ej_ready = 1'b0;
    n_checks++;
    if (bus.ej_valid !== 1'b0 || bus.link_rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL eject_handshake: ejv=%b busy=%b, required 0 0", bus.ej_valid, bus.link_rx_busy);
    end
  endtask

  // Inject 5A while receiving C3 in the same cycles.
  task automatic test_concurrent();
    logic [8:0] exp_bits;
    logic [7:0] d;
    exp_bits = 9'b010110101;
    d        = 8'hC3;
    wait_inj_ready();
    bus.ej_ready     = 1'b0;
    bus.inj_data     = 8'h5A;
    bus.inj_valid    = 1'b1;
    bus.link_rx_data = 1'b1;
    step();
    bus.inj_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      bus.link_rx_data = (c <= 8) ? d[c-1] : 1'b0;
      step();
      if (c >= 2) begin
        n_checks++;
        if (bus.link_tx_data !== exp_bits[c-2]) begin
          n_fail++;
          $display("FAIL conc_tx_c%0d: tx=%b, required %b", c, bus.link_tx_data, exp_bits[c-2]);
        end
      end
      if (c == 8) begin
        n_checks++;
        if (bus.ej_valid !== 1'b1 || bus.ej_data !== 8'hC3) begin
          n_fail++;
          $display("FAIL conc_rx: ejv=%b ejd=%h, required 1 c3", bus.ej_valid, bus.ej_data);
        end
      end
    end
    step();
    n_checks++;
    if (bus.inj_ready !== 1'b1 || bus.ej_valid !== 1'b1 || bus.ej_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL conc_end: ready=%b ejv=%b ejd=%h, required 1 1 c3", bus.inj_ready,
               bus.ej_valid, bus.ej_data);
    end
    bus.ej_ready = 1'b1;
    step();
    bus.ej_ready = 1'b0;
  endtask

  task automatic test_midframe_reset();
    logic [7:0] d;
    logic       saw_valid;
    d         = 8'h5A;
    saw_valid = 1'b0;
    bus.link_rx_data = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.link_rx_data = d[i];
      step();
    end
    bus.link_rx_data = d[4];
    reset = 1'b0;
    step();
    bus.link_rx_data = 1'b0;
    step();
    reset = 1'b1;
    n_checks++;
    if (bus.link_rx_busy !== 1'b0 || bus.ej_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b ejv=%b, required 0 0", bus.link_rx_busy, bus.ej_valid);
    end
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.ej_valid !== 1'b0 || bus.link_rx_busy !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_valid: activity seen=%b, required 0", saw_valid);
    end
  endtask

`ifdef NOC_ENDPOINT_STATS_EN
  task automatic test_stats();
    logic [7:0] d;
    n_checks++;
    if (tx_count !== 16'd0 || rx_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_cleared: tx=%0d rx=%0d, required 0 0", tx_count, rx_count);
    end
    for (int k = 0; k < 3; k++) begin
      d = 8'h11 + 8'(k);
      wait_inj_ready();
      bus.inj_data     = d;
      bus.inj_valid    = 1'b1;
      bus.link_rx_data = 1'b1;
      bus.ej_ready     = 1'b1;
      step();
      bus.inj_valid = 1'b0;
      for (int c = 1; c <= 11; c++) begin
        bus.link_rx_data = (c <= 8) ? d[c-1] : 1'b0;
        step();
      end
    end
    bus.ej_ready = 1'b0;
    n_checks++;
    if (tx_count !== 16'd3 || rx_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stats_counts: tx=%0d rx=%0d, required 3 3", tx_count, rx_count);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inj_data     = 8'h00;
    bus.inj_valid    = 1'b0;
    bus.link_tx_busy = 1'b0;
    bus.link_rx_data = 1'b0;
    bus.ej_ready     = 1'b0;
    test_reset();
    test_inject();
    test_tx_busy();
    test_eject();
    test_concurrent();
    test_midframe_reset();
`ifdef NOC_ENDPOINT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_endpoint.md
NOC_ENDPOINT -- requirements
Module: noc_endpoint

Interface
REQ-001 Parameters SHALL be: nodeid, default -1, endpoint identifier used only in simulation messages; W, default `SIZE, packet width in bits.
REQ-002 Ports SHALL be:
  - clk  input  1  clock, all logic on rising edge.
  - reset  input  1  synchronous, active-low reset.
  - inj_data  input  W  packet from host.
  - inj_valid  input  1  host offers inj_data.
  - inj_ready  output  1  endpoint accepts inj_data.
  - link_tx_data  output  1  serial line into router local RX port.
  - link_tx_busy  input  1  router local RX busy.
  - link_rx_data  input  1  serial line from router local TX port.
  - link_rx_busy  output  1  endpoint RX busy, driven back to router local TX.
  - ej_data  output  W  received packet to host.
  - ej_valid  output  1  ej_data holds a packet.
  - ej_ready  input  1  host consumes ej_data.

Function
REQ-003 Link frame SHALL be: line idle 0, one start bit of 1, then W data bits LSB first, one bit per clk.
REQ-004 Injection SHALL use a 3-state FSM:
  - T_IDLE: inj_ready=1. On inj_valid, load a shift register and go to T_WAIT.
  - T_WAIT: inj_ready=0. When link_tx_busy=0, drive start bit next cycle and go to T_SHIFT.
  - T_SHIFT: output W bits, then return to T_IDLE.
REQ-005 link_tx_data SHALL be registered; the start bit SHALL appear 2 cycles after acceptance when link_tx_busy=0, and data bit k at start+1+k.
REQ-006 inj_ready SHALL be 0 in T_WAIT and T_SHIFT; inj_ready SHALL re-assert the cycle after the last data bit is driven, allowing back-to-back frames with one idle cycle minimum.
REQ-007 link_tx_busy rising during T_SHIFT SHALL NOT abort the frame; busy is sampled only in T_WAIT.
REQ-008 Ejection SHALL use a 3-state FSM:
  - R_IDLE: on sampling link_rx_data=1, go to R_SHIFT.
  - R_SHIFT: capture W bits, then go to R_HOLD.
  - R_HOLD: ej_valid=1 until ej_ready=1, then go to R_IDLE.
REQ-009 link_rx_busy SHALL be 1 from the cycle after the start bit is sampled until the cycle after the ej_valid&ej_ready handshake; it SHALL be 0 in R_IDLE.
REQ-010 ej_data SHALL be stable while ej_valid=1; ej_valid SHALL assert the cycle after the last data bit is sampled.
REQ-011 A start bit arriving in R_HOLD SHALL be ignored (a protocol violation by the sender); under simulation, the block SHALL $display an error tagged with nodeid.
REQ-012 Injection and ejection paths SHALL operate fully concurrently and independently.
REQ-013 Bit counters SHALL be ceil(log2(W+1)) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-014 While reset=0 at a clk edge, the block SHALL be put in this state: T_IDLE, R_IDLE, inj_ready=0, link_tx_data=0, link_rx_busy=0, ej_valid=0, ej_data=0, counters=0.
REQ-015 inj_ready SHALL first assert the cycle after reset deasserts.
REQ-016 Reset mid-frame SHALL abandon partial frames and SHALL NOT emit ej_valid for them.

Configuration
REQ-017 With NOC_ENDPOINT_STATS_EN defined, the block SHALL add outputs tx_count and rx_count (16 bits each):
  - tx_count increments on each completed transmitted frame; rx_count increments on each ej handshake.
  - Both saturate at 16'hFFFF and clear on reset.
REQ-018 Without NOC_ENDPOINT_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-019 `SIZE SHALL come from the shared 2D constants include; FSM state encodings SHALL be localparams in the module.
REQ-020 The serializer (T_* FSM) SHALL be a sub-module, noc_endpoint_ser; the deserializer SHALL stay inline.

Verification
REQ-021 The bench SHALL use W=8 and cover these scenarios:
  - Inject 8'hA5 with link_tx_busy=0 -> link_tx_data carries 1,1,0,1,0,0,1,0,1 from cycle 2; inj_ready returns at cycle 11.
  - Hold link_tx_busy=1 for 5 cycles after accepting 8'h3C -> start bit only after busy falls; inj_ready stays 0 throughout.
  - Drive frame 1 + 8'h81 on link_rx_data with ej_ready=0 -> ej_valid=1 with ej_data=8'h81; link_rx_busy holds 1 until ej_ready pulses.
  - Run inject and eject simultaneously -> both complete with correct data and no interaction.
  - Assert reset=0 at data bit 4 of an incoming frame -> no ej_valid; link_rx_busy=0 after reset.
  - With NOC_ENDPOINT_STATS_EN, send 3 frames each way -> tx_count=3 and rx_count=3.
